// File: rtl/mmcm_drp_sequencer.sv
// mmcm_drp_sequencer
// Reprograms the display MMCM through its DRP port so the pixel clock can be
// switched between video modes at runtime. For each mode, a list of NUM_REGS
// {addr, mask, value} entries is fetched from an external table. Each entry is
// applied as a read-modify-write while the MMCM is held in reset. Reset is then
// released and LOCKED is awaited, with a timeout and a full-reprogram retry.
//
// Ports:
//   clk_in       board clock, also the MMCM DCLK
//   resetn       asynchronous active-low reset
//   start        one-cycle request, honoured only in IDLE
//   mode_req     target mode, captured on an accepted start
//   busy         high whenever the sequencer is not idle
//   done         one-cycle pulse on a successful reprogram + lock
//   error        sticky failure flag, cleared by the next accepted start
//   cur_mode     last successfully programmed mode
//   locked_out   synchronised LOCKED, qualified by idle and no error
//   tbl_mode     table read mode
//   tbl_index    table read index
//   tbl_entry    {addr[38:32], mask[31:16], value[15:0]}, one cycle latency
//   drp_*        MMCM dynamic reconfiguration port
//   mmcm_rst     active-high MMCM reset
//   mmcm_locked  raw asynchronous MMCM LOCKED
module mmcm_drp_sequencer #(
   parameter int MODE_W       = 2,
   parameter int NUM_REGS     = 8,
   parameter int IDX_W        = 4,
   parameter int DRDY_TIMEOUT = 255,
   parameter int LOCK_TIMEOUT = 65535,
   parameter int RETRY_MAX    = 3
) (
   input  logic              clk_in,
   input  logic              resetn,
   input  logic              start,
   input  logic [MODE_W-1:0] mode_req,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [MODE_W-1:0] cur_mode,
   output logic              locked_out,
   output logic [MODE_W-1:0] tbl_mode,
   output logic [IDX_W-1:0]  tbl_index,
   input  logic [38:0]       tbl_entry,
   output logic [6:0]        drp_daddr,
   output logic              drp_den,
   output logic              drp_dwe,
   output logic [15:0]       drp_di,
   input  logic [15:0]       drp_do,
   input  logic              drp_drdy,
   output logic              mmcm_rst,
   input  logic              mmcm_locked
);

   localparam int TMO_MAX = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int CNT_W   = $clog2(TMO_MAX + 1);
   localparam int RTY_W   = $clog2(RETRY_MAX + 1);

   localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_REGS - 1);
   localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(RETRY_MAX);

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST_ASSERT,
      ST_FETCH,
      ST_RD,
      ST_WAIT_RD,
      ST_WR,
      ST_WAIT_WR,
      ST_RST_RELEASE,
      ST_WAIT_LOCK
   } state_t;

   state_t              state_q, state_d;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic [MODE_W-1:0]   cur_mode_q, cur_mode_d;
   logic [IDX_W-1:0]    index_q, index_d;
   logic                fetch_wait_q, fetch_wait_d;
   logic [6:0]          addr_q, addr_d;
   logic [15:0]         mask_q, mask_d;
   logic [15:0]         value_q, value_d;
   logic [15:0]         di_q, di_d;
   logic [CNT_W-1:0]    tmo_q, tmo_d;
   logic [RTY_W-1:0]    retry_q, retry_d;
   logic [RTY_W-1:0]    retry_inc;
   logic                error_q, error_d;
   logic                done_q, done_d;
   logic                mmcm_rst_q, mmcm_rst_d;
   logic                pon_q, pon_d;
   logic                lock_meta_q, lock_sync_q;

   // LOCKED comes straight from the MMCM's own clock domain, so it goes
   // through a plain two-flop synchroniser before anything looks at it.
   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= mmcm_locked;
         lock_sync_q <= lock_meta_q;
      end
   end

   // State register. Reset lands in RST_RELEASE so the power-on MMCM
   // configuration is used as-is. pon_q marks that first lock, which must
   // not pulse done.
   always_ff @(posedge clk_in or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_RST_RELEASE;
         mode_q       <= '0;
         cur_mode_q   <= '0;
         index_q      <= '0;
         fetch_wait_q <= 1'b0;
         addr_q       <= '0;
         mask_q       <= '0;
         value_q      <= '0;
         di_q         <= '0;
         tmo_q        <= '0;
         retry_q      <= '0;
         error_q      <= 1'b0;
         done_q       <= 1'b0;
         mmcm_rst_q   <= 1'b1;
         pon_q        <= 1'b1;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         cur_mode_q   <= cur_mode_d;
         index_q      <= index_d;
         fetch_wait_q <= fetch_wait_d;
         addr_q       <= addr_d;
         mask_q       <= mask_d;
         value_q      <= value_d;
         di_q         <= di_d;
         tmo_q        <= tmo_d;
         retry_q      <= retry_d;
         error_q      <= error_d;
         done_q       <= done_d;
         mmcm_rst_q   <= mmcm_rst_d;
         pon_q        <= pon_d;
      end
   end

   // Next-state logic. A single counter (tmo) serves both the drdy timeout
   // and the lock timeout, since the two waits never overlap. FETCH spends
   // two cycles: the first lets the table see the new index, the second
   // latches the entry.
   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      cur_mode_d   = cur_mode_q;
      index_d      = index_q;
      fetch_wait_d = fetch_wait_q;
      addr_d       = addr_q;
      mask_d       = mask_q;
      value_d      = value_q;
      di_d         = di_q;
      tmo_d        = tmo_q;
      retry_d      = retry_q;
      error_d      = error_q;
      done_d       = 1'b0;
      mmcm_rst_d   = mmcm_rst_q;
      pon_d        = pon_q;
      retry_inc    = retry_q + RTY_W'(1);

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               mode_d  = mode_req;
               error_d = 1'b0;
               retry_d = '0;
               pon_d   = 1'b0;
               state_d = ST_RST_ASSERT;
            end
         end
         ST_RST_ASSERT: begin
            mmcm_rst_d   = 1'b1;
            index_d      = '0;
            fetch_wait_d = 1'b0;
            state_d      = ST_FETCH;
         end
         ST_FETCH: begin
            if (!fetch_wait_q) begin
               fetch_wait_d = 1'b1;
            end else begin
               fetch_wait_d = 1'b0;
               addr_d       = tbl_entry[38:32];
               mask_d       = tbl_entry[31:16];
               value_d      = tbl_entry[15:0];
               state_d      = ST_RD;
            end
         end
         ST_RD: begin
            tmo_d   = '0;
            state_d = ST_WAIT_RD;
         end
         ST_WAIT_RD: begin
            if (drp_drdy) begin
               di_d    = (drp_do & mask_q) | (value_q & ~mask_q);
               state_d = ST_WR;
            end else if (tmo_q == DRDY_LAST) begin
               error_d    = 1'b1;
               mmcm_rst_d = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
            end
         end
         ST_WR: begin
            tmo_d   = '0;
            state_d = ST_WAIT_WR;
         end
         ST_WAIT_WR: begin
            if (drp_drdy) begin
               if (index_q == IDX_LAST) begin
                  state_d = ST_RST_RELEASE;
               end else begin
                  index_d = index_q + IDX_W'(1);
                  state_d = ST_FETCH;
               end
            end else if (tmo_q == DRDY_LAST) begin
               error_d    = 1'b1;
               mmcm_rst_d = 1'b1;
               state_d    = ST_IDLE;
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
            end
         end
         ST_RST_RELEASE: begin
            mmcm_rst_d = 1'b0;
            tmo_d      = '0;
            state_d    = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (lock_sync_q) begin
               done_d     = !pon_q;
               cur_mode_d = mode_q;
               state_d    = ST_IDLE;
            end else if (tmo_q == LOCK_LAST) begin
               retry_d = retry_inc;
               if (retry_inc < RTY_LIMIT) begin
                  state_d = ST_RST_ASSERT;
               end else begin
                  error_d    = 1'b1;
                  mmcm_rst_d = 1'b1;
                  state_d    = ST_IDLE;
               end
            end else begin
               tmo_d = tmo_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs. DRP strobes are decoded from the one-cycle RD/WR states, so a
   // second transaction can only start after the previous drdy is consumed.
   always_comb begin
      busy       = (state_q != ST_IDLE);
      done       = done_q;
      error      = error_q;
      cur_mode   = cur_mode_q;
      locked_out = lock_sync_q && (state_q == ST_IDLE) && !error_q;
      tbl_mode   = mode_q;
      tbl_index  = index_q;
      drp_daddr  = addr_q;
      drp_den    = (state_q == ST_RD) || (state_q == ST_WR);
      drp_dwe    = (state_q == ST_WR);
      drp_di     = di_q;
      mmcm_rst   = mmcm_rst_q;
   end

endmodule

// File: doc/mmcm_drp_sequencer.md
Name: mmcm_drp_sequencer

Overview:
- Reprograms the display MMCM at runtime through its DRP port, so the pixel clock can switch between video modes without a new bitstream.
- Holds the MMCM in reset, read-modify-writes a per-mode list of DRP registers fetched from an external table, releases reset, then waits for LOCKED with timeout and retry.
- Runs on the free-running board clock that also drives DCLK; sits beside the MMCM wrapper in the display clocking path.

Parameters:
- MODE_W, 2, width of mode select (up to 2^MODE_W modes).
- NUM_REGS, 8, DRP writes per mode (table entries per mode), 1..16.
- IDX_W, 4, width of entry index; IDX_W >= clog2(NUM_REGS).
- DRDY_TIMEOUT, 255, cycles to wait for drp_drdy before error.
- LOCK_TIMEOUT, 65535, cycles to wait for lock after reset release.
- RETRY_MAX, 3, lock attempts (full reprogram per attempt) before error.

Ports:
- clk_in  in  1  board clock; also drives MMCM DCLK.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mode_req  in  MODE_W  target mode, captured on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful lock.
- error  out  1  sticky; cleared by the next accepted start.
- cur_mode  out  MODE_W  last successfully programmed mode.
- locked_out  out  1  synchronised LOCKED AND state==IDLE AND !error.
- tbl_mode  out  MODE_W  table read mode.
- tbl_index  out  IDX_W  table read index.
- tbl_entry  in  39  {addr[38:32], mask[31:16], value[15:0]}; valid 1 cycle after tbl_mode/tbl_index change.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable, single-cycle pulse.
- drp_dwe  out  1  DRP write enable, pulses with drp_den on writes.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data, valid with drp_drdy.
- drp_drdy  in  1  DRP ready.
- mmcm_rst  out  1  active-high MMCM reset.
- mmcm_locked  in  1  MMCM LOCKED, asynchronous; 2-flop synchronised internally.

Behaviour:
- Reset values: busy=1, done=0, error=0, cur_mode=0, locked_out=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, tbl_mode=0, tbl_index=0, mmcm_rst=1, state=RST_RELEASE, retry count=0.
- After reset, the power-on MMCM configuration is used unprogrammed: RST_RELEASE drops mmcm_rst and goes to WAIT_LOCK. Success enters IDLE with cur_mode=0 but no done pulse.
- IDLE + start: capture mode_req, clear error, retry=0, go to RST_ASSERT. start while busy is ignored.
- RST_ASSERT: mmcm_rst=1, index=0, go to FETCH.
- FETCH: drive tbl_mode/tbl_index; wait 1 cycle; latch tbl_entry; go to RD.
- RD: drp_den=1, drp_dwe=0, drp_daddr=entry.addr for one cycle; go to WAIT_RD.
- WAIT_RD: on drp_drdy, drp_di <= (drp_do & mask) | (value & ~mask); go to WR.
- WR: drp_den=drp_dwe=1 for one cycle; go to WAIT_WR.
- WAIT_WR: on drp_drdy, if index==NUM_REGS-1 go to RST_RELEASE, else increment index and go to FETCH.
- Any WAIT_RD/WAIT_WR lasting DRDY_TIMEOUT cycles without drdy: error=1, go to IDLE with mmcm_rst held 1 and cur_mode unchanged.
- RST_RELEASE: mmcm_rst=0, clear lock counter, go to WAIT_LOCK.
- WAIT_LOCK: synced locked=1 -> done pulse, cur_mode=captured mode, go to IDLE.
- Lock counter reaching LOCK_TIMEOUT: retry+1; if retry < RETRY_MAX go to RST_ASSERT (full reprogram), else error=1 and go to IDLE with mmcm_rst=1.
- DRP: never more than one transaction outstanding; drp_drdy arriving outside a WAIT state is ignored.
- Loss of lock in IDLE: locked_out falls within 2 cycles. No automatic recovery; software issues start.
- resetn asserted mid-sequence: immediate return to reset values, with mmcm_rst=1 asynchronously.

Test Plan:
- Power-on: release resetn, raise mmcm_locked 10 cycles later -> mmcm_rst falls 1 cycle after reset release, busy falls about 3 cycles after locked rises, locked_out=1, cur_mode=0, done never pulses.
- Mode switch: start with mode_req=1, NUM_REGS=8, DRP model returns 0xFFFF with drdy 3 cycles after den, entry mask=0xF000 value=0x0123 -> 8 reads and 8 writes, each drp_di=0xF123, mmcm_rst high throughout, then done pulse and cur_mode=1.
- DRDY timeout: model never asserts drdy -> error=1 after 255 cycles, busy=0, mmcm_rst=1, cur_mode unchanged.
- Lock retry: locked stays 0, LOCK_TIMEOUT=100 -> 3 full reprogram passes (24 writes), then error=1. A repeat run where locked rises in pass 2 gives done with error=0.
- Start ignored while busy, and a start after error clears error -> exactly one sequence runs per accepted start.
- resetn pulsed during the 4th DRP write -> all outputs return to reset values immediately, and the power-on lock flow restarts.
